// File: rtl/pip_skid_stage_pkg.sv
// pip_skid_stage_pkg: state encoding and default widths for the elastic pipeline stage
package pip_skid_stage_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pip_state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/pip_skid_stage_sat_counter.sv
// pip_skid_stage_sat_counter: saturating event counter, cleared only by rst
module pip_skid_stage_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pip_skid_stage.sv
// pip_skid_stage: valid/ready pipeline stage with 2-entry skid buffer, flush-to-bubble and stall counter
module pip_skid_stage
  import pip_skid_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  pip_state_e state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic in_fire, out_fire, ld_main, ld_skid, from_skid;
  assign in_ready  = state != ST_FULL;
  assign out_valid = state != ST_EMPTY;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  always_comb begin
    state_nxt = state;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        state_nxt = in_fire ? ST_ONE : ST_EMPTY;
        ld_main   = in_fire;
      end
      ST_ONE: begin
        state_nxt = (in_fire && !out_fire) ? ST_FULL : (!in_fire && out_fire) ? ST_EMPTY : ST_ONE;
        ld_main   = in_fire && out_fire;
        ld_skid   = in_fire && !out_fire;
      end
      ST_FULL: begin
        state_nxt = out_fire ? ST_ONE : ST_FULL;
        ld_main   = out_fire;
        from_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // flush drops the incoming entry and leaves main untouched so out_data holds
    if (flush) begin
      state_nxt = ST_EMPTY;
      ld_main   = 1'b0;
      ld_skid   = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (ld_main) begin
        main_data <= from_skid ? skid_data : in_data;
        main_ctrl <= from_skid ? skid_ctrl : in_ctrl;
      end
      if (ld_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  pip_skid_stage_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );
endmodule

// File: tb/tb_pip_skid_stage.sv
// tb_pip_skid_stage: directed and randomized checks against a queue-based reference model
module tb_pip_skid_stage;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [15:0] in_ctrl, out_ctrl;
  logic [CNT_W-1:0] stall_cnt;
  int checks = 0, errors = 0;
  logic [31:0] qd[$];
  logic [15:0] qc[$];
  logic [31:0] last_data = '0;
  logic [31:0] emitted[$];
  int mcnt = 0;
  always #5 clk = ~clk;
  pip_skid_stage #(.DATA_W(32), .CTRL_W(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock: drive, compare against the model mid-cycle, then advance the model at the edge
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] d,
                      input logic [15:0] c, input logic o, input bit ck = 1'b1);
    bit mv, mr;
    rst = r; flush = f; in_valid = v; in_data = d; in_ctrl = c; out_ready = o;
    @(negedge clk);
    mv = qd.size() > 0;
    mr = qd.size() < 2;
    if (ck) begin
      chk("in_ready", 64'(in_ready), 64'(mr));
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("out_data", 64'(out_data), 64'(mv ? qd[0] : last_data));
      chk("out_ctrl", 64'(out_ctrl), 64'(mv ? qc[0] : 16'h0));
      chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
    end
    @(posedge clk);
    if (r) begin
      qd.delete(); qc.delete(); mcnt = 0; last_data = '0;
    end else begin
      if (mv && !o && mcnt < CNT_MAX) mcnt++;
      if (mv && o) begin
        emitted.push_back(qd[0]);
        void'(qd.pop_front()); void'(qc.pop_front());
      end
      if (f) begin
        qd.delete(); qc.delete();
      end else if (v && mr) begin
        qd.push_back(d); qc.push_back(c);
      end
      if (qd.size() > 0) last_data = qd[0];
    end
    #1;
  endtask
  initial begin
    int pre;
    // reset with in_valid asserted; DUT state is unknown before the first edge
    step(1, 0, 1, 32'hdead, 16'hbeef, 0, 0);
    step(1, 0, 1, 32'hdead, 16'hbeef, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    // streaming 1..10
    emitted.delete();
    for (int i = 1; i <= 10; i++) step(0, 0, 1, i, 16'(i + 100), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("stream_count", 64'(emitted.size()), 64'd10);
    foreach (emitted[i]) chk("stream_order", 64'(emitted[i]), 64'(i + 1));
    // back-pressure: A,B fill the stage, C waits upstream
    emitted.delete();
    step(0, 0, 1, 32'hA, 16'h1, 0);
    step(0, 0, 1, 32'hB, 16'h2, 0);
    step(0, 0, 1, 32'hC, 16'h3, 0);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    step(0, 0, 1, 32'hC, 16'h3, 1);
    step(0, 0, 1, 32'hC, 16'h3, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_count", 64'(emitted.size()), 64'd3);
    chk("bp_a", 64'(emitted[0]), 64'hA);
    chk("bp_b", 64'(emitted[1]), 64'hB);
    chk("bp_c", 64'(emitted[2]), 64'hC);
    // flush in FULL while D is offered
    emitted.delete();
    step(0, 0, 1, 32'h11, 16'h5, 0);
    step(0, 0, 1, 32'h12, 16'h6, 0);
    step(0, 0, 0, 0, 0, 0);
    pre = int'(stall_cnt);
    step(0, 1, 1, 32'hD, 16'h7, 0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_stall", 64'(stall_cnt), 64'(pre < CNT_MAX ? pre + 1 : CNT_MAX));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    chk("flush_no_d", 64'(emitted.size()), 64'd0);
    // saturation: hold one entry with out_ready=0 for 20 cycles
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h55, 16'h9, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
    chk("sat_stall", 64'(stall_cnt), 64'(CNT_MAX));
    // randomized traffic
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 999) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
           $urandom, 16'($urandom), $urandom_range(0, 2) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
